icache: RTL

Direct-mapped, read-only L1 instruction cache between the fetch stage and the instruction memory. Word lookups hit combinationally in the same cycle. A miss stalls fetch, requests the whole block from instruction memory over its ren/ready interface, writes the block into the array, and replays the lookup. It is the only master of the instruction memory port.

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_array.sv | 48 ++++
 rtl/icache.sv | 109 ++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// Shared icache geometry, memory-port widths and FSM state encodings.
package icache_pkg;

   localparam int IBLOCK_SIZE_BITS     = 128;
   localparam int IMEM_BLOCK_ADDR_SIZE = 28;

   localparam int ICACHE_SETS        = 64;
   localparam int ICACHE_INDEX_SIZE  = $clog2(ICACHE_SETS);
   localparam int ICACHE_OFFSET_SIZE = $clog2(IBLOCK_SIZE_BITS / 32);
   localparam int ICACHE_TAG_SIZE    = 32 - 2 - ICACHE_OFFSET_SIZE - ICACHE_INDEX_SIZE;

   typedef logic [1:0] ic_state_t;

   localparam ic_state_t IC_LOOKUP = 2'd0;
   localparam ic_state_t IC_REQ    = 2'd1;
   localparam ic_state_t IC_FETCH  = 2'd2;
   localparam ic_state_t IC_WRITE  = 2'd3;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped icache: combinational read,
// single synchronous write port, valid bits cleared asynchronously on reset.
module icache_array
   import icache_pkg::*;
#(
   parameter int SETS   = ICACHE_SETS,
   parameter int IDX_W  = ICACHE_INDEX_SIZE,
   parameter int TAG_W  = ICACHE_TAG_SIZE,
   parameter int DATA_W = IBLOCK_SIZE_BITS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [IDX_W-1:0]  rd_index_i,
   output logic              rd_valid_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_index_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [DATA_W-1:0] wr_data_i
);

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [DATA_W-1:0] data_q [SETS];

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_index_i] <= 1'b1;
      end
   end

   // NOTE: tag/data storage has no reset; the valid bits alone make stale contents harmless.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         tag_q[wr_index_i]  <= wr_tag_i;
         data_q[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only L1 instruction cache: same-cycle hits, whole-block
// refill from instruction memory on a miss, then the lookup is replayed.
module icache
   import icache_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int BLOCK_WORDS = IBLOCK_SIZE_BITS / 32,
   parameter int NUM_SETS    = ICACHE_SETS
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            cpu_ren,
   input  logic [ADDR_W-1:0]               cpu_addr,
   output logic [31:0]                     cpu_dout,
   output logic                            cpu_stall,
   output logic                            mem_ren,
   output logic [IMEM_BLOCK_ADDR_SIZE-1:0] mem_block_address,
   input  logic                            mem_ready,
   input  logic [IBLOCK_SIZE_BITS-1:0]     mem_dout
);

   localparam int OFF_W     = $clog2(BLOCK_WORDS);
   localparam int IDX_W     = $clog2(NUM_SETS);
   localparam int TAG_W     = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int BLK_SHIFT = OFF_W + 2;
   localparam int DATA_W    = BLOCK_WORDS * 32;

   ic_state_t                       state_q, state_d;
   logic [IMEM_BLOCK_ADDR_SIZE-1:0] blk_addr_q, blk_addr_d;
   logic [DATA_W-1:0]               fill_q, fill_d;

   logic [OFF_W-1:0]  offset;
   logic [IDX_W-1:0]  index;
   logic [TAG_W-1:0]  tag;
   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [DATA_W-1:0] rd_data;
   logic              hit;
   logic              addr_unused;

   assign offset      = cpu_addr[2 +: OFF_W];
   assign index       = cpu_addr[2 + OFF_W +: IDX_W];
   assign tag         = cpu_addr[ADDR_W-1 -: TAG_W];
   assign addr_unused = ^cpu_addr[1:0];

   // The latched block address carries the fill's index in its low bits and its tag above.
   icache_array #(
      .SETS   (NUM_SETS),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clock      (clock),
      .reset      (reset),
      .rd_index_i (index),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .wr_en_i    (state_q == IC_WRITE),
      .wr_index_i (blk_addr_q[IDX_W-1:0]),
      .wr_tag_i   (blk_addr_q[IDX_W +: TAG_W]),
      .wr_data_i  (fill_q)
   );

   assign hit = rd_valid && (rd_tag == tag);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      blk_addr_d = blk_addr_q;
      fill_d     = fill_q;
      case (state_q)
         IC_LOOKUP: begin
            if (cpu_ren && !hit) begin
               blk_addr_d = cpu_addr[BLK_SHIFT +: IMEM_BLOCK_ADDR_SIZE];
               state_d    = IC_REQ;
            end
         end
         // mem_ready may still be high from the previous fill, so it is not looked at here.
         IC_REQ:   state_d = IC_FETCH;
         IC_FETCH: begin
            if (mem_ready) begin
               fill_d  = mem_dout;
               state_d = IC_WRITE;
            end
         end
         IC_WRITE: state_d = IC_LOOKUP;
         default:  state_d = IC_LOOKUP;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IC_LOOKUP;
         blk_addr_q <= '0;
         fill_q     <= '0;
      end else begin
         state_q    <= state_d;
         blk_addr_q <= blk_addr_d;
         fill_q     <= fill_d;
      end
   end

   assign mem_ren           = (state_q == IC_REQ) || (state_q == IC_FETCH);
   assign mem_block_address = mem_ren ? blk_addr_q : '0;
   assign cpu_stall         = ((state_q == IC_LOOKUP) && cpu_ren && !hit) || (state_q != IC_LOOKUP);
   assign cpu_dout          = (cpu_ren && !cpu_stall) ? rd_data[32*offset +: 32] : 32'h0;

endmodule
